// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types and constants for the pipelined immediate generator.
// Immediate format codes, RV32I/RV64I major opcodes that carry an immediate,
// and the output-buffer occupancy state.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // EMPTY: nothing held; ONE: output register full; FULL: output + skid full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: purely combinational immediate extraction for all five RISC-V
// immediate formats, sign-extended to XLEN (legal XLEN: 32 or 64).
// Optional macro IMM_GEN_ILLEGAL_EN adds the o_illegal flag.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
`ifdef IMM_GEN_ILLEGAL_EN
    output logic            o_illegal,
`endif
    output fmt_e            o_fmt
);

    logic [31:0] w_imm32;
    fmt_e        w_fmt;

    // Select the format from the opcode and assemble its 32-bit sign-extended immediate.
    always_comb begin
        w_imm32 = 32'd0;
        w_fmt   = FMT_NONE;
        case (i_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                w_fmt   = FMT_I;
            end
            OP_STORE: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_fmt   = FMT_S;
            end
            OP_BRANCH: begin
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
                w_fmt   = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32 = {i_instr[31:12], 12'd0};
                w_fmt   = FMT_U;
            end
            OP_JAL: begin
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
                w_fmt   = FMT_J;
            end
            default: begin
                // Unknown opcode: clean zero, never a leftover value.
                w_imm32 = 32'd0;
                w_fmt   = FMT_NONE;
            end
        endcase
    end

    // Every 32-bit form already carries its sign in bit 31, so widening is a
    // plain signed extension (U on RV64 replicates bit 31 into 63:32).
    assign o_imm = XLEN'($signed(w_imm32));
    assign o_fmt = w_fmt;

`ifdef IMM_GEN_ILLEGAL_EN
    // Compressed/non-32-bit encodings are flagged even if the opcode decodes.
    assign o_illegal = (w_fmt == FMT_NONE) || (i_instr[1:0] != 2'b11);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with a two-entry skid buffer.
// One-cycle latency, full throughput, ready_o driven only from registered
// state and rst_i. Optional macro IMM_GEN_ILLEGAL_EN adds illegal_o.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
`ifdef IMM_GEN_ILLEGAL_EN
    output logic             illegal_o,
`endif
    output logic [TAG_W-1:0] tag_o
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ILLEGAL_EN
        logic             ill;
`endif
    } entry_t;

    state_e r_state;
    entry_t r_out;
    entry_t r_skid;

    entry_t          w_new;
    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_in_xfer;
    logic            w_out_xfer;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_instr   (instr_i),
        .o_imm     (w_imm),
`ifdef IMM_GEN_ILLEGAL_EN
        .o_illegal (w_new.ill),
`endif
        .o_fmt     (w_fmt)
    );

    assign w_new.imm = w_imm;
    assign w_new.fmt = w_fmt;
    assign w_new.tag = tag_i;

    assign ready_o    = (r_state != ST_FULL) && !rst_i;
    assign valid_o    = (r_state != ST_EMPTY);
    assign w_in_xfer  = valid_i && ready_o;
    assign w_out_xfer = valid_o && ready_i;

    // Skid FSM: tracks occupancy and moves entries input -> output/skid -> output in FIFO order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_out   <= w_new;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        r_skid  <= w_new;
                        r_state <= ST_FULL;
                    end else if (!w_in_xfer && w_out_xfer) begin
                        r_state <= ST_EMPTY;
                    end else if (w_in_xfer && w_out_xfer) begin
                        // Pass-through: the drained slot is refilled in the same edge.
                        r_out   <= w_new;
                        r_state <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so only the drain side can move.
                    if (w_out_xfer) begin
                        r_out   <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign imm_o = r_out.imm;
    assign fmt_o = r_out.fmt;
    assign tag_o = r_out.tag;
`ifdef IMM_GEN_ILLEGAL_EN
    assign illegal_o = r_out.ill;
`endif

endmodule
